img_pixel_streamer: RTL and testbench

// - Raster-scan reader for the image BRAM ROM (24-bit pixel, 3 x s8 channels, 1-cycle read latency).
// - Generates ROM EN/ADDR and inserts zero padding around the frame.
// - Emits one padded pixel per beat on a valid/ready stream to the first conv layer's line buffer.
// - Sustains 1 beat/cycle under continuous ready; never drops or duplicates a beat under backpressure.

---
 rtl/img_pkg.sv | 48 ++++
 rtl/img_pixel_streamer_if.sv | 22 ++
 rtl/pix_skid_fifo.sv | 66 ++++++
 rtl/img_pixel_streamer.sv | 185 ++++++++++++++++++
 tb/tb_img_pixel_streamer.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/img_pkg.sv
// ============================================================================
//  Module : img_pkg
//  Brief  : Shared types, defaults and helpers for the image pixel streamer.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package img_pkg;

    localparam int PIX_W     = 24;
    localparam int CH_W      = 8;
    localparam int DEF_IMG_W = 224;
    localparam int DEF_IMG_H = 224;
    localparam int DEF_PAD   = 1;

    typedef logic [PIX_W-1:0] pix_t;

    typedef struct packed {
        pix_t data;
        logic eol;
        logic eof;
    } beat_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // ROM address width for a w x h image.
    function automatic int addr_w(input int w, input int h);
        return cnt_w(w * h);
    endfunction

    // True when v lies in [lo, lo+n); done in int so a zero lower bound is not
    // a constant-true unsigned compare.
    function automatic logic in_band(input int v, input int lo, input int n);
        return (v >= lo) && (v < lo + n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/img_pixel_streamer_if.sv
// ============================================================================
//  Module : img_pixel_streamer_if
//  Brief  : valid/ready pixel stream carrying one padded pixel per beat.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface img_pixel_streamer_if;
    import img_pkg::*;

    logic valid;
    logic ready;
    pix_t data;
    logic eol;
    logic eof;

    modport master (output valid, output data, output eol, output eof, input ready);
    modport slave  (input valid, input data, input eol, input eof, output ready);

endinterface

`default_nettype wire

// File: rtl/pix_skid_fifo.sv
// ============================================================================
//  Module : pix_skid_fifo
//  Brief  : Two-entry output buffer of stream beats; head is shown directly.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pix_skid_fifo
    import img_pkg::*;
(
    input  wire logic       CLK,
    input  wire logic       RST,
    input  wire logic       push,
    input  wire beat_t      push_data,
    input  wire logic       pop,
    output beat_t           head,
    output logic [1:0]      count,
    output logic            full,
    output logic            empty
);

    beat_t       r_mem [2];
    logic        r_wr;
    logic        r_rd;
    logic [1:0]  r_count;
    logic        w_push_ok;
    logic        w_pop_ok;

    assign count = r_count;
    assign full  = (r_count == 2'd2);
    assign empty = (r_count == 2'd0);
    assign head  = r_mem[r_rd];

    // A pop frees the head slot in the same cycle, so a full FIFO can still
    // take a push when it is also being popped.
    assign w_pop_ok  = pop && !empty;
    assign w_push_ok = push && (!full || w_pop_ok);

    // Storage, pointers and occupancy.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_wr    <= 1'b0;
            r_rd    <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr] <= push_data;
                r_wr        <= ~r_wr;
            end
            if (w_pop_ok) begin
                r_rd <= ~r_rd;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/img_pixel_streamer.sv
// ============================================================================
//  Module : img_pixel_streamer
//  Brief  : Raster-scan image ROM reader that inserts a zero border and emits
//           one padded pixel per beat on a valid/ready stream.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module img_pixel_streamer
    import img_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int PAD    = DEF_PAD,
    parameter int ADDR_W = addr_w(IMG_W, IMG_H)
)(
    input  wire logic              CLK,
    input  wire logic              RST,
    input  wire logic              start,
    output logic                   busy,
    output logic                   done,
    output logic                   rom_en,
    output logic [ADDR_W-1:0]      rom_addr,
    input  wire pix_t              rom_dout,
    img_pixel_streamer_if.master   m
);

    localparam int PW    = IMG_W + 2 * PAD;
    localparam int PH    = IMG_H + 2 * PAD;
    localparam int COL_W = cnt_w(PW);
    localparam int ROW_W = cnt_w(PH + 1);
    localparam int NPIX  = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(NPIX - 1);
    localparam logic [COL_W-1:0]  c_last_col  = COL_W'(PW - 1);
    localparam logic [ROW_W-1:0]  c_last_row  = ROW_W'(PH - 1);

    state_t              r_state;
    state_t              w_state_nx;
    logic [ROW_W-1:0]    r_row;
    logic [COL_W-1:0]    r_col;
    logic [ADDR_W-1:0]   r_next_addr;
    logic [ADDR_W-1:0]   r_last_addr;
    logic                r_infl;
    logic                r_infl_pad;
    logic                r_infl_eol;
    logic                r_infl_eof;
    logic                r_done;

    logic                w_issue;
    logic                w_credit;
    logic                w_inside;
    logic                w_last_col;
    logic                w_last_coord;
    logic                w_pop;
    beat_t               w_push_data;
    beat_t               w_head;
    logic [1:0]          w_fifo_count;
    logic                w_fifo_full;
    logic                w_fifo_empty;

    assign w_last_col   = (r_col == c_last_col);
    assign w_last_coord = w_last_col && (r_row == c_last_row);
    assign w_inside     = in_band(int'(r_row), PAD, IMG_H) && in_band(int'(r_col), PAD, IMG_W);
    assign w_pop        = m.valid && m.ready;

    // Issue only when the beat can be guaranteed a FIFO slot when it returns.
    // A pop in this cycle frees a slot, which is what lets a steady ready
    // stream run at one beat per cycle. A full FIFO can only accept a new
    // issue when it is popping now and nothing is already in flight.
    assign w_credit = w_fifo_full
                    ? (w_pop && !r_infl)
                    : ((int'(w_fifo_count) + int'(r_infl) - int'(w_pop)) < 2);

    // Next-state, issue strobe and ROM enable.
    always_comb begin
        w_state_nx = r_state;
        w_issue    = 1'b0;
        rom_en     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                w_issue = w_credit;
                rom_en  = w_credit && w_inside;
                if (w_credit && w_last_coord) begin
                    w_state_nx = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_pop && w_head.eof) begin
                    w_state_nx = ST_IDLE;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    assign busy     = (r_state != ST_IDLE);
    assign done     = r_done;
    // The address port shows the issuing address, otherwise the last one used.
    assign rom_addr = rom_en ? r_next_addr : r_last_addr;

    // FSM state register and end-of-frame pulse.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_done  <= (r_state == ST_DRAIN) && w_pop && w_head.eof;
        end
    end

    // Padded raster coordinates and the unpadded ROM address counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_row       <= '0;
            r_col       <= '0;
            r_next_addr <= '0;
            r_last_addr <= '0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_row       <= '0;
            r_col       <= '0;
            r_next_addr <= '0;
        end else if (w_issue) begin
            if (w_last_col) begin
                r_col <= '0;
                r_row <= r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
            if (rom_en) begin
                r_last_addr <= r_next_addr;
                // Saturate so the counter never points past the last pixel.
                if (r_next_addr != c_last_addr) begin
                    r_next_addr <= r_next_addr + ADDR_W'(1);
                end
            end
        end
    end

    // One-cycle tag that travels alongside the ROM read (or pad slot).
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_infl     <= 1'b0;
            r_infl_pad <= 1'b0;
            r_infl_eol <= 1'b0;
            r_infl_eof <= 1'b0;
        end else begin
            r_infl     <= w_issue;
            r_infl_pad <= !w_inside;
            r_infl_eol <= w_last_col;
            r_infl_eof <= w_last_coord;
        end
    end

    assign w_push_data.data = r_infl_pad ? '0 : rom_dout;
    assign w_push_data.eol  = r_infl_eol;
    assign w_push_data.eof  = r_infl_eof;

    pix_skid_fifo u_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (r_infl),
        .push_data (w_push_data),
        .pop       (w_pop),
        .head      (w_head),
        .count     (w_fifo_count),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    assign m.valid = !w_fifo_empty;
    assign m.data  = w_head.data;
    assign m.eol   = w_head.eol;
    assign m.eof   = w_head.eof;

endmodule

`default_nettype wire

// File: tb/tb_img_pixel_streamer.sv
// ============================================================================
//  Module : tb_img_pixel_streamer
//  Brief  : Directed, scoreboard-based bench for img_pixel_streamer.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_img_pixel_streamer;
    import img_pkg::*;

    typedef struct packed {
        logic [23:0] d;
        logic        eol;
        logic        eof;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a;
    logic        start_b;
    logic        busy_a, done_a, rom_en_a;
    logic        busy_b, done_b, rom_en_b;
    logic [3:0]  rom_addr_a;
    logic [3:0]  rom_addr_b;
    logic [23:0] rom_dout_a = '0;
    logic [23:0] rom_dout_b = '0;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];

    img_pixel_streamer_if if_a ();
    img_pixel_streamer_if if_b ();

    img_pixel_streamer #(.IMG_W(4), .IMG_H(3), .PAD(1)) dut_a (
        .CLK      (clk),
        .RST      (rst),
        .start    (start_a),
        .busy     (busy_a),
        .done     (done_a),
        .rom_en   (rom_en_a),
        .rom_addr (rom_addr_a),
        .rom_dout (rom_dout_a),
        .m        (if_a.master)
    );

    img_pixel_streamer #(.IMG_W(4), .IMG_H(4), .PAD(0)) dut_b (
        .CLK      (clk),
        .RST      (rst),
        .start    (start_b),
        .busy     (busy_b),
        .done     (done_b),
        .rom_en   (rom_en_b),
        .rom_addr (rom_addr_b),
        .rom_dout (rom_dout_b),
        .m        (if_b.master)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] rom_val(input int kind, input int i);
        if (kind == 0) return 24'(i + 1);
        return 24'h5A0000 + 24'(i * 24'h010101);
    endfunction

    // One-cycle-latency ROM models.
    always @(posedge clk) begin
        if (rom_en_a) rom_dout_a <= rom_val(0, int'(rom_addr_a));
        if (rom_en_b) rom_dout_b <= rom_val(1, int'(rom_addr_b));
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pushes the expected padded frame for a w x h image with border p.
    task automatic build_exp(input int w, input int h, input int p, input int kind);
        int pw = w + 2 * p;
        int ph = h + 2 * p;
        exp_t e;
        exp_q.delete();
        for (int r = 0; r < ph; r++) begin
            for (int c = 0; c < pw; c++) begin
                if (r >= p && r < p + h && c >= p && c < p + w)
                    e.d = rom_val(kind, (r - p) * w + (c - p));
                else
                    e.d = 24'h0;
                e.eol = (c == pw - 1);
                e.eof = (c == pw - 1) && (r == ph - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic pop_cmp(input string tag, input logic [23:0] d, input logic eol, input logic eof);
        exp_t e;
        if (exp_q.size() == 0) begin
            check({tag, "_extra_beat"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_data"}, 32'(d),   32'(e.d));
            check({tag, "_eol"},  32'(eol), 32'(e.eol));
            check({tag, "_eof"},  32'(eof), 32'(e.eof));
        end
    endtask

    // One frame on the padded 4x3 instance.
    // mode 0: ready always high; mode 1: ready high one cycle in three.
    task automatic run_a(input int mode, input int rst_beat, input bit skip_start,
                         input bit poke, input bit start_on_done);
        int          beats = 0;
        int          dones = 0;
        bit          held  = 1'b0;
        bit          fin   = 1'b0;
        bit          abort = 1'b0;
        logic [23:0] held_d = '0;
        build_exp(4, 3, 1, 0);
        if (!skip_start) begin
            @(negedge clk);
            start_a = 1'b1;
        end
        @(negedge clk);
        start_a = 1'b0;
        for (int k = 0; k < 400 && !fin; k++) begin
            if (k > 0) @(negedge clk);
            if_a.ready = (mode == 0) ? 1'b1 : (k % 3 == 2);
            start_a    = poke && (k == 8);
            #1;
            if (k <= 2) check("a_first_valid", 32'(if_a.valid), 32'(k == 2));
            if (held) begin
                check("a_stall_valid", 32'(if_a.valid), 32'd1);
                check("a_stall_data",  32'(if_a.data),  32'(held_d));
            end
            held   = if_a.valid && !if_a.ready;
            held_d = if_a.data;
            if (rst_beat >= 0 && if_a.valid && beats == rst_beat) begin
                rst = 1'b1;
                #1;
                check("a_rst_valid", 32'(if_a.valid), 32'd0);
                check("a_rst_busy",  32'(busy_a),     32'd0);
                check("a_rst_done",  32'(done_a),     32'd0);
                @(negedge clk);
                rst   = 1'b0;
                exp_q.delete();
                abort = 1'b1;
                fin   = 1'b1;
            end else if (done_a) begin
                dones++;
                check("a_done_busy",  32'(busy_a), 32'd0);
                check("a_done_beats", 32'(beats),  32'd30);
                fin = 1'b1;
                if (start_on_done) start_a = 1'b1;
            end else begin
                check("a_busy", 32'(busy_a), 32'd1);
                if (if_a.valid && if_a.ready) begin
                    pop_cmp("a", if_a.data, if_a.eol, if_a.eof);
                    beats++;
                end
            end
        end
        if (!fin) check("a_timeout", 32'd1, 32'd0);
        if (!abort) begin
            check("a_done_count", 32'(dones), 32'd1);
            check("a_queue_left", 32'(exp_q.size()), 32'd0);
        end
    endtask

    // One frame on the unpadded 4x4 instance with ready held high.
    task automatic run_b();
        int beats = 0;
        int naddr = 0;
        bit fin   = 1'b0;
        build_exp(4, 4, 0, 1);
        if_b.ready = 1'b1;
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int k = 0; k < 200 && !fin; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            if (k <= 2)  check("b_first_valid", 32'(if_b.valid), 32'(k == 2));
            if (k <= 17) check("b_rom_en_run",  32'(rom_en_b),   32'(k < 16));
            if (rom_en_b) begin
                check("b_rom_addr", 32'(rom_addr_b), 32'(naddr));
                naddr++;
            end
            if (done_b) begin
                check("b_done_beats", 32'(beats), 32'd16);
                fin = 1'b1;
            end else if (if_b.valid && if_b.ready) begin
                pop_cmp("b", if_b.data, if_b.eol, if_b.eof);
                beats++;
            end
        end
        if (!fin) check("b_timeout", 32'd1, 32'd0);
        check("b_addr_count", 32'(naddr), 32'd16);
        check("b_queue_left", 32'(exp_q.size()), 32'd0);
        check("b_addr_hold",  32'(rom_addr_b), 32'd15);
    endtask

    initial begin
        rst        = 1'b1;
        start_a    = 1'b0;
        start_b    = 1'b0;
        if_a.ready = 1'b0;
        if_b.ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy",     32'(busy_a),     32'd0);
        check("rst_done",     32'(done_a),     32'd0);
        check("rst_rom_en",   32'(rom_en_a),   32'd0);
        check("rst_rom_addr", 32'(rom_addr_a), 32'd0);
        check("rst_valid",    32'(if_a.valid), 32'd0);
        check("rst_data",     32'(if_a.data),  32'd0);
        check("rst_eol",      32'(if_a.eol),   32'd0);
        check("rst_eof",      32'(if_a.eof),   32'd0);
        check("rst_b_busy",   32'(busy_b),     32'd0);
        check("rst_b_valid",  32'(if_b.valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_a(0, -1, 1'b0, 1'b0, 1'b0);   // continuous ready
        run_a(1, -1, 1'b0, 1'b0, 1'b1);   // stalled ready, restart in done cycle
        run_a(0, 12, 1'b1, 1'b0, 1'b0);   // restarted frame, reset on beat 12
        run_a(0, -1, 1'b0, 1'b1, 1'b0);   // fresh frame, start poked while busy
        run_b();                          // no border, address sequence

        repeat (2) @(negedge clk);
        #1;
        check("end_a_idle", 32'(busy_a), 32'd0);
        check("end_b_idle", 32'(busy_b), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
